// File: rtl/traffic_light_ctrl_p.sv
// Highway / local-road traffic light controller with parametrised phase
// timing, LR green extension, flashing night mode and a countdown output.
module traffic_light_ctrl_p #(
   parameter int GREEN_MIN    = 8,
   parameter int YELLOW_CYC   = 3,
   parameter int ALLRED_CYC   = 1,
   parameter int LR_GREEN_CYC = 4,
   parameter int LR_EXT_MAX   = 2,
   parameter int FLASH_HALF   = 4,
   parameter int CNT_W        = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             LR_has_Car,
   input  logic             flash_en,
   output logic [2:0]       HW_light,
   output logic [2:0]       LR_light,
   output logic [CNT_W-1:0] timer,
   output logic [2:0]       state_o
);

   localparam logic [2:0] HW_G  = 3'b000;
   localparam logic [2:0] HW_Y  = 3'b001;
   localparam logic [2:0] HW_R  = 3'b010;
   localparam logic [2:0] LR_G  = 3'b100;
   localparam logic [2:0] LR_Y  = 3'b101;
   localparam logic [2:0] LR_R  = 3'b110;
   localparam logic [2:0] FLASH = 3'b111;

   localparam logic [2:0] L_G = 3'b100;
   localparam logic [2:0] L_Y = 3'b010;
   localparam logic [2:0] L_R = 3'b001;
   localparam logic [2:0] L_O = 3'b000;

   localparam logic [CNT_W-1:0] LD_GREEN = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LD_YEL   = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] LD_ARED  = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] LD_LRG   = CNT_W'(LR_GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_FLASH = CNT_W'(FLASH_HALF - 1);

   // one spare bit keeps the counter legal when LR_EXT_MAX is 0
   localparam int EXT_W = $clog2(LR_EXT_MAX + 2);
   localparam logic [EXT_W-1:0] EXT_MAX = EXT_W'(LR_EXT_MAX);

   logic [2:0]       state, state_n;
   logic [CNT_W-1:0] tmr, tmr_n;
   logic [EXT_W-1:0] ext_cnt, ext_cnt_n;
   logic             phase, phase_n;
   logic             tmr_zero;

   assign tmr_zero = (tmr == '0);

   always_comb begin
      state_n   = state;
      tmr_n     = tmr_zero ? tmr : tmr - 1'b1;
      ext_cnt_n = ext_cnt;
      phase_n   = phase;
      case (state)
         HW_G: begin
            if (flash_en) begin
               state_n = FLASH;
               tmr_n   = LD_FLASH;
               phase_n = 1'b1;
            end else if (tmr_zero && LR_has_Car) begin
               state_n = HW_Y;
               tmr_n   = LD_YEL;
            end
         end
         HW_Y: begin
            if (tmr_zero) begin
               state_n = HW_R;
               tmr_n   = LD_ARED;
            end
         end
         HW_R: begin
            if (tmr_zero) begin
               state_n   = LR_G;
               tmr_n     = LD_LRG;
               ext_cnt_n = '0;
            end
         end
         LR_G: begin
            // each extension re-arms a single cycle at timer 0
            if (tmr_zero) begin
               if (LR_has_Car && ext_cnt < EXT_MAX) begin
                  tmr_n     = '0;
                  ext_cnt_n = ext_cnt + 1'b1;
               end else begin
                  state_n = LR_Y;
                  tmr_n   = LD_YEL;
               end
            end
         end
         LR_Y: begin
            if (tmr_zero) begin
               state_n = LR_R;
               tmr_n   = LD_ARED;
            end
         end
         LR_R: begin
            if (tmr_zero) begin
               state_n = HW_G;
               tmr_n   = LD_GREEN;
            end
         end
         FLASH: begin
            if (!flash_en) begin
               state_n = LR_R;
               tmr_n   = LD_ARED;
            end else if (tmr_zero) begin
               phase_n = ~phase;
               tmr_n   = LD_FLASH;
            end
         end
         default: begin
            state_n = HW_G;
            tmr_n   = LD_GREEN;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= HW_G;
         tmr     <= LD_GREEN;
         ext_cnt <= '0;
         phase   <= 1'b0;
      end else begin
         state   <= state_n;
         tmr     <= tmr_n;
         ext_cnt <= ext_cnt_n;
         phase   <= phase_n;
      end
   end

   always_comb begin
      HW_light = L_R;
      LR_light = L_R;
      case (state)
         HW_G:    HW_light = L_G;
         HW_Y:    HW_light = L_Y;
         LR_G:    LR_light = L_G;
         LR_Y:    LR_light = L_Y;
         FLASH: begin
            HW_light = phase ? L_Y : L_O;
            LR_light = phase ? L_R : L_O;
         end
         default: ;
      endcase
   end

   assign timer   = tmr;
   assign state_o = state;

endmodule

// File: doc/traffic_light_ctrl_p.md
# traffic_light_ctrl_p

Parametrised two-road traffic light controller for a highway (HW) / local road (LR) intersection, the successor to the fixed-timing controller. Every phase duration is a parameter. New behaviour: LR green extension while cars keep arriving, a flashing night mode, and a remaining-time output for a countdown display. Sits between the synchronised car sensor / mode switch and the lamp drivers.

## Interface
- GREEN_MIN, 8: minimum HW green cycles (≥1)
- YELLOW_CYC, 3: yellow duration for either road (≥1)
- ALLRED_CYC, 1: all-red guard after each yellow (≥1)
- LR_GREEN_CYC, 4: base LR green cycles (≥1)
- LR_EXT_MAX, 2: maximum single-cycle LR green extensions per LR green phase (≥0)
- FLASH_HALF, 4: cycles per half-period of the flash blink (≥1)
- CNT_W, 8: timer width; every duration parameter must be ≤ 2^CNT_W
- CLK  in  1: clock, rising edge
- RESET  in  1: asynchronous, active-low reset
- LR_has_Car  in  1: LR car present, synchronous to CLK
- flash_en  in  1: request flashing night mode, synchronous
- HW_light  out  3: {green,yellow,red}, one-hot or 000
- LR_light  out  3: {green,yellow,red}, one-hot or 000
- timer  out  CNT_W: cycles remaining in current phase minus 1
- state_o  out  3: current state code

## Operation
- Registered state, timer, ext_cnt (0..LR_EXT_MAX), flash phase bit. Light outputs decode from the registered state only (Moore).
- State codes and lights (HW/LR):
  - HW_G=000: 100/001
  - HW_Y=001: 010/001
  - HW_R=010: 001/001
  - LR_G=100: 001/100
  - LR_Y=101: 001/010
  - LR_R=110: 001/001
  - FLASH=111: phase ? 010/001 : 000/000
- On every transition the timer loads (new phase duration − 1). Otherwise it decrements when nonzero. Transitions occur only on a cycle with timer==0, except where noted.
- HW_G, timer==0, LR_has_Car=1 → HW_Y. With timer==0 and no car, HW_G holds at timer 0 indefinitely.
- HW_G, flash_en=1 (any timer value) → FLASH, with phase=1 and timer=FLASH_HALF−1. Flash has priority over car.
- HW_Y → HW_R → LR_G. Entering LR_G clears ext_cnt.
- LR_G, timer==0:
  - LR_has_Car=1 and ext_cnt<LR_EXT_MAX: stay, timer=0, ext_cnt+1. Each extension adds exactly one cycle.
  - Otherwise → LR_Y.
- LR_Y → LR_R → HW_G (timer=GREEN_MIN−1).
- FLASH:
  - timer==0: toggle phase, reload FLASH_HALF−1.
  - flash_en=0 sampled on any cycle → LR_R (all red, ALLRED_CYC), then HW_G.
- flash_en outside HW_G is ignored until HW_G is reached. The normal sequence is never cut short.
- Undefined code (011) → HW_G with timer=GREEN_MIN−1.

## Timing
- Reset asserted: immediately state=HW_G, timer=GREEN_MIN−1, ext_cnt=0, phase=0, HW_light=100, LR_light=001, state_o=000. Applies mid-phase as well.
- After reset release, the first CLK edge decrements the timer.
- Phase durations in cycles:
  - HW_Y = YELLOW_CYC, HW_R = ALLRED_CYC.
  - LR_G = LR_GREEN_CYC + extensions (0..LR_EXT_MAX).
  - LR_Y = YELLOW_CYC, LR_R = ALLRED_CYC.
  - HW_G ≥ GREEN_MIN.
- Input to light latency: 1 cycle. An input sampled at edge k changes the lights after edge k.
- Never both roads non-red. No green→red without yellow, except HW_G→FLASH, which is permitted.

## Test plan
With GREEN_MIN=4, YELLOW_CYC=2, ALLRED_CYC=1, LR_GREEN_CYC=3, LR_EXT_MAX=2, FLASH_HALF=2, CNT_W=4:
- Reset, LR_has_Car=0 for 20 cycles -> HW_light=100 and LR_light=001 throughout; timer goes 3,2,1,0 then holds 0.
- LR_has_Car=1 from reset release, held -> HW_G 4, HW_Y 2, HW_R 1, LR_G 5 (3+2 extensions), LR_Y 2, LR_R 1, then HW_G for 4 cycles and repeat. Check LR_light=100 for exactly 5 cycles.
- Car present only until the LR_G timer first reaches 0, then dropped -> LR_G lasts exactly 3 cycles; ext_cnt stays 0.
- flash_en=1 in HW_G at timer=2 with car=1 -> next state FLASH. HW_light toggles 010,010,000,000,… and LR_light toggles 001,001,000,000,…. Drop flash_en -> LR_R for 1 cycle, then HW_G with timer=3.
- flash_en pulsed during LR_G -> ignored; sequence unchanged.
- Assert RESET low mid-LR_Y -> outputs immediately 100/001, timer=3, state_o=000. Release -> normal HW_G countdown.
